// File: rtl/mac_seq_ctrl_pkg.sv
// Shared definitions for the MAC sequencer: default datapath widths and
// the sequencer state encoding.
package mac_pkg;

  localparam int A_WIDTH   = 8;
  localparam int W_WIDTH   = 8;
  localparam int P_WIDTH   = 32;
  localparam int LEN_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ACCUM = ST_ACCUM,
    S_DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Job, operand and result handshakes of the MAC sequencer.
// The master side issues jobs and operand pairs and consumes results.
// The slave side is the sequencer itself.
interface mac_seq_ctrl_if #(
  parameter int A_WIDTH   = mac_pkg::A_WIDTH,
  parameter int W_WIDTH   = mac_pkg::W_WIDTH,
  parameter int P_WIDTH   = mac_pkg::P_WIDTH,
  parameter int LEN_WIDTH = mac_pkg::LEN_WIDTH
);

  logic                        start;
  logic        [LEN_WIDTH-1:0] vec_len;
  logic signed [P_WIDTH-1:0]   bias;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [A_WIDTH-1:0]   in_a;
  logic signed [W_WIDTH-1:0]   in_w;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [P_WIDTH-1:0]   out_result;
  logic                        out_ovf;
  logic                        busy;

  modport master (
    output start, vec_len, bias, in_valid, in_a, in_w, out_ready,
    input  in_ready, out_valid, out_result, out_ovf, busy
  );

  modport slave (
    input  start, vec_len, bias, in_valid, in_a, in_w, out_ready,
    output in_ready, out_valid, out_result, out_ovf, busy
  );

endinterface

// File: rtl/mac_seq_ctrl_mac.sv
// MAC_Unit: combinational multiply-accumulate.
// Computes out_p = in_p + in_a*in_w with a full-precision signed product.
// The sum wraps modulo 2^P_WIDTH.
module MAC_Unit #(
  parameter int A_WIDTH = mac_pkg::A_WIDTH,
  parameter int W_WIDTH = mac_pkg::W_WIDTH,
  parameter int P_WIDTH = mac_pkg::P_WIDTH
) (
  input  logic signed [A_WIDTH-1:0] in_a,
  input  logic signed [W_WIDTH-1:0] in_w,
  input  logic signed [P_WIDTH-1:0] in_p,
  output logic signed [P_WIDTH-1:0] out_p
);

  localparam int PROD_WIDTH = A_WIDTH + W_WIDTH;

  logic signed [PROD_WIDTH-1:0] product;

  // Widen both operands before multiplying so no product bits are lost,
  // then sign-extend the product and add it with wraparound
  always_comb begin
    product = PROD_WIDTH'(in_a) * PROD_WIDTH'(in_w);
    out_p   = P_WIDTH'(product) + in_p;
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: time-multiplexes one MAC_Unit to compute
// bias + sum(a[i]*w[i]) over a streamed vector.
// The result is reported with a sticky signed-overflow flag.
module mac_seq_ctrl #(
  parameter int A_WIDTH   = mac_pkg::A_WIDTH,
  parameter int W_WIDTH   = mac_pkg::W_WIDTH,
  parameter int P_WIDTH   = mac_pkg::P_WIDTH,
  parameter int LEN_WIDTH = mac_pkg::LEN_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  mac_seq_ctrl_if.slave bus
);

  import mac_pkg::*;

  state_t                    state_q, state_d;
  logic signed [P_WIDTH-1:0] acc_q, acc_d;
  logic signed [P_WIDTH-1:0] mac_out;
  logic [LEN_WIDTH-1:0]      cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic                      ovf_q, ovf_d;
  logic                      prod_neg;
  logic                      ovf_now;

  MAC_Unit #(
    .A_WIDTH (A_WIDTH),
    .W_WIDTH (W_WIDTH),
    .P_WIDTH (P_WIDTH)
  ) u_mac (
    .in_a  (bus.in_a),
    .in_w  (bus.in_w),
    .in_p  (acc_q),
    .out_p (mac_out)
  );

  // Overflow on this beat: product and accumulator share a sign but the
  // sum does not; a zero operand yields a non-negative product
  always_comb begin
    prod_neg = (bus.in_a != '0) && (bus.in_w != '0) &&
               (bus.in_a[A_WIDTH-1] ^ bus.in_w[W_WIDTH-1]);
    ovf_now  = (prod_neg == acc_q[P_WIDTH-1]) &&
               (mac_out[P_WIDTH-1] != acc_q[P_WIDTH-1]);
  end

  // Next-state, datapath updates and handshake outputs; registers hold by default
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    len_d          = len_q;
    ovf_d          = ovf_q;
    bus.in_ready   = 1'b0;
    bus.out_valid  = 1'b0;
    bus.out_result = '0;
    bus.out_ovf    = 1'b0;
    bus.busy       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d   = bus.bias;
          len_d   = bus.vec_len;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = (bus.vec_len == '0) ? S_DONE : S_ACCUM;
        end
      end

      S_ACCUM: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
        if (bus.in_valid) begin
          acc_d = mac_out;
          cnt_d = cnt_q + 1'b1;
          ovf_d = ovf_q | ovf_now;
          if (cnt_q == len_q - 1'b1) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        bus.out_valid  = 1'b1;
        bus.out_result = acc_q;
        bus.out_ovf    = ovf_q;
        bus.busy       = 1'b1;
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl.
// Runs a table of jobs plus random jobs through a result scoreboard.
// Hand-written sequences cover reset mid-job and stray starts.
module tb_mac_seq_ctrl;

  typedef struct packed {
    logic signed [31:0] bias;
    logic [7:0]         len;
    logic [5:0][7:0]    a;
    logic [5:0][7:0]    w;
    logic [3:0]         gap;
    logic [3:0]         delay;
    logic               stray;
    logic signed [31:0] exp_result;
    logic               exp_ovf;
  } job_t;

  typedef struct packed {
    logic [31:0] result;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  int   assert_count = 0;
  int   fail_count   = 0;
  exp_t exp_q[$];
  job_t jobs[8];

  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.A_WIDTH(8), .W_WIDTH(8), .P_WIDTH(32), .LEN_WIDTH(8)) bus ();

  mac_seq_ctrl #(.A_WIDTH(8), .W_WIDTH(8), .P_WIDTH(32), .LEN_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic job_t mkJob(input int bias, input int len, input int av[6], input int wv[6],
                                 input int gap, input int delay, input bit stray,
                                 input int exp_result, input bit exp_ovf);
    job_t j;
    j.bias = bias;
    j.len  = 8'(len);
    for (int i = 0; i < 6; i++) begin
      j.a[i] = 8'(av[i]);
      j.w[i] = 8'(wv[i]);
    end
    j.gap        = 4'(gap);
    j.delay      = 4'(delay);
    j.stray      = stray;
    j.exp_result = exp_result;
    j.exp_ovf    = exp_ovf;
    return j;
  endfunction

  // Reference model: exact 64-bit sums, overflow when a partial sum leaves the int32 range
  function automatic job_t modelJob(input job_t j);
    longint acc = longint'(j.bias);
    longint s;
    bit     ovf = 1'b0;
    for (int i = 0; i < int'(j.len); i++) begin
      s = acc + longint'($signed(j.a[i])) * longint'($signed(j.w[i]));
      if (s > 64'sd2147483647 || s < -64'sd2147483648) ovf = 1'b1;
      acc = longint'(int'(s));
    end
    j.exp_result = int'(acc);
    j.exp_ovf    = ovf;
    return j;
  endfunction

  // Result scoreboard: every accepted result must match the oldest outstanding job
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected result handshake", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("out_result", bus.out_result, e.result);
        checkOutput("out_ovf", 32'(bus.out_ovf), 32'(e.ovf));
      end
    end
  end

  task automatic applyStimulus(input job_t j);
    int waited;
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.vec_len   = j.len;
    bus.bias      = j.bias;
    bus.out_ready = (j.delay == 0);
    exp_q.push_back('{j.exp_result, j.exp_ovf});
    if (j.len == 0) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 8'sd9;
      bus.in_w     = 8'sd9;
    end
    @(posedge clk); #1;
    bus.start   = j.stray;
    bus.bias    = 32'h5A5A5A5A;
    bus.vec_len = 8'd7;

    for (int i = 0; i < int'(j.len); i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = j.a[i];
      bus.in_w     = j.w[i];
      waited       = 0;
      @(negedge clk);
      if (i == 0) checkOutput("busy in ACCUM", 32'(bus.busy), 32'd1);
      while (!bus.in_ready && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (!bus.in_ready) begin
        checkOutput("in_ready timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk); #1;
      if (i < int'(j.len) - 1 && j.gap > 0) begin
        bus.in_valid = 1'b0;
        bus.in_a     = 8'sh7F;
        bus.in_w     = 8'sh7F;
        repeat (int'(j.gap)) @(posedge clk);
        #1;
      end
    end
    if (j.len != 0) bus.in_valid = 1'b0;
    bus.start = 1'b0;

    @(negedge clk);
    checkOutput("out_valid latency", 32'(bus.out_valid), 32'd1);
    if (j.len == 0) checkOutput("no in_ready zero-length", 32'(bus.in_ready), 32'd0);
    waited = 0;
    while (!bus.out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.out_valid) begin
      checkOutput("out_valid timeout", 32'd0, 32'd1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      return;
    end
    for (int k = 0; k < int'(j.delay); k++) begin
      checkOutput("held out_result", bus.out_result, j.exp_result);
      checkOutput("held out_valid", 32'(bus.out_valid), 32'd1);
      if (k < int'(j.delay) - 1) @(negedge clk);
    end
    if (j.delay > 0) begin
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    checkOutput("out_valid drops", 32'(bus.out_valid), 32'd0);
    checkOutput("busy drops", 32'(bus.busy), 32'd0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " in_ready"}, 32'(bus.in_ready), 32'd0);
    checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, " out_result"}, bus.out_result, 32'd0);
    checkOutput({tag, " out_ovf"}, 32'(bus.out_ovf), 32'd0);
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    job_t j;
    jobs[0] = mkJob(100, 3, '{5, -5, -5, 0, 0, 0}, '{10, 10, -10, 0, 0, 0}, 0, 0, 0, 150, 0);
    jobs[1] = mkJob(-7, 0, '{0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0}, 0, 0, 0, -7, 0);
    jobs[2] = mkJob(-200, 2, '{120, 5, 0, 0, 0, 0}, '{0, 10, 0, 0, 0, 0}, 3, 5, 0, -150, 0);
    jobs[3] = mkJob(32'h7FFFFFFF, 1, '{1, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0}, 0, 0, 0,
                    32'h80000000, 1);
    jobs[4] = mkJob(5, 2, '{3, -2, 0, 0, 0, 0}, '{4, 6, 0, 0, 0, 0}, 0, 0, 0, 5, 0);
    jobs[5] = mkJob(32'h80000000, 1, '{-1, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0}, 0, 1, 0,
                    32'h7FFFFFFF, 1);
    jobs[6] = mkJob(32'h7FFFFFFF, 2, '{1, 1, 0, 0, 0, 0}, '{1, 1, 0, 0, 0, 0}, 1, 0, 0,
                    32'h80000001, 1);
    jobs[7] = mkJob(0, 3, '{-128, -128, 127, 0, 0, 0}, '{-128, 127, 127, 0, 0, 0}, 1, 2, 1,
                    16257, 0);

    rst           = 1'b1;
    bus.start     = 1'b1;
    bus.vec_len   = 8'd3;
    bus.bias      = 32'd55;
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'sd1;
    bus.in_w      = 8'sd1;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    $display("[TB] table-driven jobs");
    for (int t = 0; t < 8; t++) applyStimulus(jobs[t]);

    $display("[TB] reset during a job");
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.vec_len = 8'd4;
    bus.bias    = 32'd1000;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = 8'sd3;
    bus.in_w     = 8'sd3;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkIdleOutputs("mid-job reset");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("no out_valid after reset", 32'(bus.out_valid), 32'd0);
    end
    applyStimulus(mkJob(0, 1, '{-5, 0, 0, 0, 0, 0}, '{-10, 0, 0, 0, 0, 0}, 0, 0, 1, 50, 0));

    $display("[TB] random jobs");
    for (int r = 0; r < 6; r++) begin
      j       = '0;
      j.bias  = $urandom();
      j.len   = 8'($urandom_range(1, 6));
      for (int i = 0; i < 6; i++) begin
        j.a[i] = 8'($urandom_range(0, 255));
        j.w[i] = 8'($urandom_range(0, 255));
      end
      j.gap   = 4'($urandom_range(0, 2));
      j.delay = 4'($urandom_range(0, 2));
      j.stray = 1'($urandom_range(0, 1));
      applyStimulus(modelJob(j));
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  // Global watchdog so a stuck handshake still terminates the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer that time-multiplexes one MAC_Unit to compute a biased dot product, result = bias + sum(a[i]*w[i]) for i = 0..vec_len-1.
- Operand pairs arrive on a valid/ready stream.
- The accumulator is fed back into the MAC in_p input.
- The final sum is presented on a valid/ready output with a sticky overflow flag.
- Sits between the operand buffers and the PE result path. It is also the unit the BIST controller drives.

Parameters:
A_WIDTH, 8, activation operand width (signed)
W_WIDTH, 8, weight operand width (signed)
P_WIDTH, 32, accumulator/result width (signed)
LEN_WIDTH, 8, width of the vector-length field

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  job request; honoured only in IDLE
vec_len  in  LEN_WIDTH  number of (a,w) pairs; sampled on accepted start
bias  in  P_WIDTH  signed initial accumulator value; sampled on accepted start
in_valid  in  1  operand pair valid
in_ready  out  1  sequencer accepts a pair this cycle
in_a  in  A_WIDTH  signed activation
in_w  in  W_WIDTH  signed weight
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  P_WIDTH  signed accumulated result
out_ovf  out  1  signed overflow occurred during this job (valid with out_valid)
busy  out  1  high in ACCUM and DONE

Behaviour:
Interface: one clock, clk; reset is synchronous and active-high, rst. Fixed.

Reset:
- On rst=1 at a clk edge: state=IDLE, acc=0, cnt=0, len_q=0, ovf_q=0.
- All outputs are 0: in_ready=0, out_valid=0, out_result=0, out_ovf=0, busy=0.
- Reset mid-job discards the partial sum. No output handshake is produced for that job.

States:
- IDLE
  - in_ready=0, out_valid=0.
  - On start=1: acc<=bias, len_q<=vec_len, cnt<=0, ovf_q<=0.
  - Next state is ACCUM, or DONE if vec_len==0.
- ACCUM
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready.
  - On a beat: acc<=MAC(in_a,in_w,acc), cnt<=cnt+1, ovf_q<=ovf_q|ovf_now.
  - If cnt==len_q-1 on the beat, go to DONE.
  - No beat: hold all registers (bubbles allowed indefinitely).
- DONE
  - out_valid=1, out_result=acc, out_ovf=ovf_q.
  - Outputs are held stable while out_ready=0.
  - On out_ready=1: go to IDLE, out_valid drops the next cycle.

Latency:
- out_valid rises the cycle after the last beat is accepted.
- For vec_len==0, out_valid rises the cycle after start, with out_result=bias.
- Minimum job length is vec_len+2 cycles including the return to IDLE.

Arithmetic:
- The product is a full signed A_WIDTH+W_WIDTH value, sign-extended to P_WIDTH.
- The sum wraps modulo 2^P_WIDTH. This is identical to MAC_Unit.
- ovf_now=1 when the product sign equals the acc sign and the result sign differs from both.
- The product sign is 0 if either operand is 0.

Simultaneous events:
- start while busy: ignored, no queuing.
- start in the same cycle as the DONE handshake: ignored. The new job needs start in IDLE.
- in_valid outside ACCUM: ignored (in_ready=0).
- rst has priority over everything.

Decomposition:
- Shared package mac_pkg holds:
  - the default widths A_WIDTH/W_WIDTH/P_WIDTH;
  - the state encoding localparams ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_DONE=2'd2.
- One sub-module: the existing MAC_Unit, instantiated once with in_p tied to the acc register.
- The overflow detector stays inline.

Test Plan:
- Basic job:
  - Stimulus: bias=100, vec_len=3, pairs (5,10),(-5,10),(-5,-10) on consecutive cycles, out_ready=1.
  - Required response: out_valid one cycle after the 3rd beat, out_result=150, out_ovf=0, busy low the cycle after.
- Zero-length job:
  - Stimulus: vec_len=0, bias=-7.
  - Required response: out_valid the cycle after start, out_result=-7, no in_ready pulse.
- Bubbles and backpressure:
  - Stimulus: vec_len=2, pairs (120,0),(5,10) with bias=-200, in_valid low for 3 cycles between beats, out_ready low for 5 cycles.
  - Required response: out_result=-150 held stable all 5 cycles, handshake on the first out_ready=1.
- Overflow:
  - Stimulus: bias=2147483647, vec_len=1, pair (1,1).
  - Required response: out_result=-2147483648 (0x80000000), out_ovf=1. The next job without overflow reports out_ovf=0.
- Reset and stray start:
  - Stimulus: rst after 2 of 4 beats, then a new job with bias=0 and pair (-5,-10); start pulses during ACCUM are ignored.
  - Required response: result 50, no spurious out_valid.
